// File: rtl/dmem_pkg.sv
// Shared types and constants for the cache-side memory responder.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 32;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_CNT_W  = 4;

    localparam logic [DMEM_DATA_W-1:0] DMEM_BAD_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Request as captured from the cpu in the IDLE cycle
    typedef struct packed {
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic                   wen;
    } dmem_req_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with registered read port; a write echoes its data.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   we,
    input  logic [DEPTH_LOG2-1:0]  index,
    input  logic [DMEM_DATA_W-1:0] wdata,
    output logic [DMEM_DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DMEM_DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DMEM_DATA_W-1:0] r_rdata;

    // Storage array carries no reset so it can map onto block RAM
    always_ff @(posedge clock) begin
        if (en && we) begin
            r_mem[index] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (en) begin
            r_rdata <= we ? wdata : r_mem[index];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the cpu cache-side memory port: IDLE/BUSY/RESP sequencer with programmable wait states.
// Optional feature macro: DMEM_RANGE_CHECK_EN (adds sticky err output, rejects out-of-range/misaligned addresses).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DMEM_ADDR_W-1:0] addr,
    input  logic [DMEM_DATA_W-1:0] wdata,
    input  logic                   wen,
    output logic [DMEM_DATA_W-1:0] rdata,
`ifdef DMEM_RANGE_CHECK_EN
    output logic                   err,
`endif
    output logic                   rdy
);

    dmem_state_e             r_state;
    logic [DMEM_CNT_W-1:0]   r_cnt;
    dmem_req_t               r_req;
    logic                    r_rdy;

    dmem_req_t               w_cur;
    logic                    w_go_resp;
    logic                    w_bad;
    logic                    w_ram_en;
    logic                    w_ram_we;
    logic [DEPTH_LOG2-1:0]   w_index;
    logic [DMEM_DATA_W-1:0]  w_ram_rdata;

    // With one wait state the RAM is accessed on the sampling edge, so it must see the live inputs
    assign w_cur     = (r_state == ST_IDLE) ? dmem_req_t'{addr: addr, wdata: wdata, wen: wen} : r_req;
    assign w_go_resp = ((r_state == ST_IDLE) && (LATENCY == 1)) ||
                       ((r_state == ST_BUSY) && (r_cnt == '0));
    assign w_index   = w_cur.addr[DEPTH_LOG2+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    assign w_bad = ((w_cur.addr >> (DEPTH_LOG2 + 2)) != '0) || (w_cur.addr[1:0] != 2'b00);
`else
    logic w_unused_addr;
    assign w_bad         = 1'b0;
    assign w_unused_addr = ^{w_cur.addr[DMEM_ADDR_W-1:DEPTH_LOG2+2], w_cur.addr[1:0]};
`endif

    // A reset on the commit edge discards the pending write
    assign w_ram_en = w_go_resp && !reset && !w_bad;
    assign w_ram_we = w_ram_en && w_cur.wen;

    dmem_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .index (w_index),
        .wdata (w_cur.wdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_req   <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_rdy <= w_go_resp;
            case (r_state)
                ST_IDLE: begin
                    r_req <= w_cur;
                    if (LATENCY == 1) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt   <= DMEM_CNT_W'(LATENCY - 2);
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - DMEM_CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic r_bad;
    logic r_err;

    // r_bad selects the poison word for the response in flight and holds it afterwards
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bad <= 1'b0;
            r_err <= 1'b0;
        end else if (w_go_resp) begin
            r_bad <= w_bad;
            r_err <= r_err | w_bad;
        end
    end

    assign rdata = r_bad ? DMEM_BAD_DATA : w_ram_rdata;
    assign err   = r_err;
`else
    assign rdata = w_ram_rdata;
`endif

    assign rdy = r_rdy;

endmodule
